// File: rtl/reg_scoreboard.sv
// Read-side hazard guard for the register file: per-register pending-write
// counters that stall decode on pending sources or a saturated destination.
module reg_scoreboard #(
  parameter int unsigned NREGS          = 32,
  parameter int unsigned CNT_W          = 2,
  parameter bit          ZERO_HARDWIRED = 1'b1,
  parameter bit          WB_BYPASS      = 1'b1,
  localparam int unsigned IDX_W         = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [IDX_W-1:0] id_src1,
  input  logic             id_src1_used,
  input  logic [IDX_W-1:0] id_src2,
  input  logic             id_src2_used,
  input  logic [IDX_W-1:0] id_dest,
  input  logic             id_wr_en,
  output logic             id_ready,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_dest,
  output logic             busy,
  output logic             sb_err,
  output logic [31:0]      stall_cycles
);

  logic [CNT_W-1:0] r_cnt     [NREGS];
  logic [CNT_W-1:0] w_cnt_nxt [NREGS];
  logic             r_busy;
  logic             r_sb_err;
  logic [31:0]      r_stall;

  logic [NREGS-1:0] w_tracked;
  logic [NREGS-1:0] w_wb_hit;
  logic [NREGS-1:0] w_pend;
  logic [NREGS-1:0] w_src_haz;
  logic             w_dest_full;
  logic             w_issue;
  logic             w_any_nxt;
  logic             w_wb_err;
  logic             w_inc;
  logic             w_dec;

  always_comb begin
    w_tracked = '0;
    w_wb_hit  = '0;
    w_pend    = '0;
    w_src_haz = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      w_tracked[r] = !(ZERO_HARDWIRED && (r == 0));
      w_wb_hit[r]  = wb_en && (wb_dest == IDX_W'(r));
      w_pend[r]    = (r_cnt[r] != '0) && w_tracked[r];
      // Retiring the last pending write this cycle releases the reader now.
      w_src_haz[r] = w_pend[r] &&
                     !(WB_BYPASS && w_wb_hit[r] && (r_cnt[r] == CNT_W'(1)));
    end
  end

  always_comb begin
    w_dest_full = id_wr_en && w_tracked[id_dest] && (r_cnt[id_dest] == '1) &&
                  !w_wb_hit[id_dest];
    id_ready    = !((id_src1_used && w_src_haz[id_src1]) ||
                    (id_src2_used && w_src_haz[id_src2]) ||
                    w_dest_full);
    w_issue     = id_valid && id_ready && id_wr_en && w_tracked[id_dest];
    w_wb_err    = wb_en && w_tracked[wb_dest] && (r_cnt[wb_dest] == '0);
  end

  always_comb begin
    w_any_nxt = 1'b0;
    w_inc     = 1'b0;
    w_dec     = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      w_inc = w_issue && (id_dest == IDX_W'(r));
      w_dec = w_wb_hit[r] && w_pend[r];
      w_cnt_nxt[r] = r_cnt[r];
      if (w_inc && !w_dec)
        w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
      else if (w_dec && !w_inc)
        w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
      w_any_nxt = w_any_nxt || (w_cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++)
        r_cnt[r] <= '0;
      r_busy   <= 1'b0;
      r_sb_err <= 1'b0;
      r_stall  <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++)
        r_cnt[r] <= w_cnt_nxt[r];
      r_busy <= w_any_nxt;
      if (w_wb_err)
        r_sb_err <= 1'b1;
      if (id_valid && !id_ready && (r_stall != '1))
        r_stall <= r_stall + 32'd1;
    end
  end

  assign busy         = r_busy;
  assign sb_err       = r_sb_err;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazard stall, bypass, saturation,
// same-cycle issue/writeback, sticky error, async reset and r0 handling.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_src1;
  logic        id_src1_used;
  logic [4:0]  id_src2;
  logic        id_src2_used;
  logic [4:0]  id_dest;
  logic        id_wr_en;
  logic        id_ready;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic        busy;
  logic        sb_err;
  logic [31:0] stall_cycles;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] exp_stall;

  reg_scoreboard #(
    .NREGS(32),
    .CNT_W(2),
    .ZERO_HARDWIRED(1'b1),
    .WB_BYPASS(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_src1(id_src1),
    .id_src1_used(id_src1_used),
    .id_src2(id_src2),
    .id_src2_used(id_src2_used),
    .id_dest(id_dest),
    .id_wr_en(id_wr_en),
    .id_ready(id_ready),
    .wb_en(wb_en),
    .wb_dest(wb_dest),
    .busy(busy),
    .sb_err(sb_err),
    .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after each posedge; checks happen before the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src1 = '0; id_src1_used = 0; id_src2 = '0; id_src2_used = 0;
    id_dest = '0; id_wr_en = 0; wb_en = 0; wb_dest = '0;
  endtask

  task automatic issue_dest(input logic [4:0] d);
    idle();
    id_valid = 1; id_wr_en = 1; id_dest = d;
    step();
  endtask

  task automatic writeback(input logic [4:0] d);
    idle();
    wb_en = 1; wb_dest = d;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #1;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", id_ready); end
    checks++;
    step(); step();
    rst_n = 1;
    step();
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sberr got %b exp 0", sb_err); end
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    checks++;
    exp_stall = 0;
  endtask

  task automatic test_bypass();
    issue_dest(5'd5);
    idle();
    id_valid = 1; id_src1 = 5'd5; id_src1_used = 1;
    #1;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", id_ready); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL raw_busy got %b exp 1", busy); end
    checks++;
    id_src1_used = 0;
    #1;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL unused_src got %b exp 1", id_ready); end
    checks++;
    id_src1_used = 1;
    step(); exp_stall++;
    if (stall_cycles !== exp_stall) begin errors++; $display("FAIL stall_cnt1 got %0d exp %0d", stall_cycles, exp_stall); end
    checks++;
    id_src1_used = 0; id_src2 = 5'd5; id_src2_used = 1;
    #1;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL src2_stall got %b exp 0", id_ready); end
    checks++;
    step(); exp_stall++;
    if (stall_cycles !== exp_stall) begin errors++; $display("FAIL stall_cnt2 got %0d exp %0d", stall_cycles, exp_stall); end
    checks++;
    wb_en = 1; wb_dest = 5'd5;
    #1;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL wb_bypass got %b exp 1", id_ready); end
    checks++;
    step();
    if (busy !== 1'b0) begin errors++; $display("FAIL bypass_busy got %b exp 0", busy); end
    checks++;
    if (stall_cycles !== exp_stall) begin errors++; $display("FAIL stall_hold got %0d exp %0d", stall_cycles, exp_stall); end
    checks++;
    idle();
  endtask

  task automatic test_saturate();
    issue_dest(5'd7); issue_dest(5'd7); issue_dest(5'd7);
    idle();
    id_valid = 1; id_wr_en = 1; id_dest = 5'd7;
    #1;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL dest_full got %b exp 0", id_ready); end
    checks++;
    step(); exp_stall++;
    wb_en = 1; wb_dest = 5'd7;
    #1;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL full_wb_ready got %b exp 1", id_ready); end
    checks++;
    step();
    idle();
    id_wr_en = 1; id_dest = 5'd7;
    #1;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL still_full got %b exp 0", id_ready); end
    checks++;
    writeback(5'd7);
    idle();
    id_src1 = 5'd7; id_src1_used = 1; wb_en = 1; wb_dest = 5'd7;
    #1;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL no_bypass_cnt2 got %b exp 0", id_ready); end
    checks++;
    writeback(5'd7);
    idle();
    id_src1 = 5'd7; id_src1_used = 1; wb_en = 1; wb_dest = 5'd7;
    #1;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL bypass_cnt1 got %b exp 1", id_ready); end
    checks++;
    writeback(5'd7);
    idle();
    if (busy !== 1'b0) begin errors++; $display("FAIL sat_drain_busy got %b exp 0", busy); end
    checks++;
    if (sb_err !== 1'b0) begin errors++; $display("FAIL sat_sberr got %b exp 0", sb_err); end
    checks++;
    if (stall_cycles !== exp_stall) begin errors++; $display("FAIL sat_stall got %0d exp %0d", stall_cycles, exp_stall); end
    checks++;
  endtask

  task automatic test_same_cycle();
    issue_dest(5'd9);
    idle();
    id_valid = 1; id_wr_en = 1; id_dest = 5'd9; wb_en = 1; wb_dest = 5'd9;
    step();
    idle();
    id_src1 = 5'd9; id_src1_used = 1;
    #1;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_pend got %b exp 0", id_ready); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL same_cycle_busy got %b exp 1", busy); end
    checks++;
    if (sb_err !== 1'b0) begin errors++; $display("FAIL same_cycle_sberr got %b exp 0", sb_err); end
    checks++;
    writeback(5'd9);
    idle();
    if (busy !== 1'b0) begin errors++; $display("FAIL same_cycle_drain got %b exp 0", busy); end
    checks++;
  endtask

  task automatic test_sb_err();
    writeback(5'd12);
    idle();
    if (sb_err !== 1'b1) begin errors++; $display("FAIL sberr_set got %b exp 1", sb_err); end
    checks++;
    issue_dest(5'd3);
    writeback(5'd3);
    idle();
    step();
    if (sb_err !== 1'b1) begin errors++; $display("FAIL sberr_sticky got %b exp 1", sb_err); end
    checks++;
  endtask

  task automatic test_async_reset();
    issue_dest(5'd5); issue_dest(5'd5);
    idle();
    id_src1 = 5'd5; id_src1_used = 1;
    #1;
    if (id_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_pend got %b exp 0", id_ready); end
    checks++;
    #1;
    rst_n = 0;
    #1;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL async_clr_ready got %b exp 1", id_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL async_clr_busy got %b exp 0", busy); end
    checks++;
    if (sb_err !== 1'b0) begin errors++; $display("FAIL async_clr_sberr got %b exp 0", sb_err); end
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL async_clr_stall got %0d exp 0", stall_cycles); end
    checks++;
    exp_stall = 0;
    step();
    rst_n = 1;
    step();
    if (id_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", id_ready); end
    checks++;
    idle();
  endtask

  task automatic test_zero();
    issue_dest(5'd0);
    idle();
    id_valid = 1; id_src1 = 5'd0; id_src1_used = 1;
    #1;
    if (id_ready !== 1'b1) begin errors++; $display("FAIL r0_src_ready got %b exp 1", id_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL r0_busy got %b exp 0", busy); end
    checks++;
    step();
    writeback(5'd0);
    idle();
    if (sb_err !== 1'b0) begin errors++; $display("FAIL r0_wb_sberr got %b exp 0", sb_err); end
    checks++;
    if (stall_cycles !== exp_stall) begin errors++; $display("FAIL r0_stall got %0d exp %0d", stall_cycles, exp_stall); end
    checks++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = 0;
    rst_n = 1;
    idle();
    #1;
    test_reset();
    test_bypass();
    test_saturate();
    test_same_cycle();
    test_sb_err();
    test_async_reset();
    test_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
